// File: rtl/cop_dispatcher_if.sv
// Core <-> coprocessor-slot bundle handled by cop_dispatcher.
// The R_* and E_* operand fields go straight from the core to every cop and
// never pass through the dispatcher, so they are not part of this bundle.
interface cop_dispatcher_if #(
  parameter int NUM_COP = 2
);

  // Core side
  logic                   FLUSH;
  logic                   STALL;
  logic                   C_VALID;
  logic [16:0]            C_OPCODE;
  logic                   C_ACCEPT;
  logic                   E_ALLOW;
  logic                   E_VALID;
  logic                   E_REG_W_EN;
  logic [4:0]             E_REG_W_RD;
  logic [31:0]            E_REG_W_DATA;
  logic                   E_EXC_EN;
  logic [3:0]             E_EXC_CODE;

  // Coprocessor side, slot i at bit i or at [i*W +: W]
  logic [16:0]            CP_C_OPCODE;
  logic [NUM_COP-1:0]     CP_C_ACCEPT;
  logic [NUM_COP-1:0]     CP_E_ALLOW;
  logic [NUM_COP-1:0]     CP_E_VALID;
  logic [NUM_COP-1:0]     CP_E_REG_W_EN;
  logic [NUM_COP-1:0]     CP_E_EXC_EN;
  logic [5*NUM_COP-1:0]   CP_E_REG_W_RD;
  logic [32*NUM_COP-1:0]  CP_E_REG_W_DATA;
  logic [4*NUM_COP-1:0]   CP_E_EXC_CODE;

  // Dispatcher view
  modport slave (
    input  FLUSH, STALL, C_VALID, C_OPCODE, E_ALLOW,
           CP_C_ACCEPT, CP_E_VALID, CP_E_REG_W_EN, CP_E_EXC_EN,
           CP_E_REG_W_RD, CP_E_REG_W_DATA, CP_E_EXC_CODE,
    output C_ACCEPT, E_VALID, E_REG_W_EN, E_REG_W_RD, E_REG_W_DATA,
           E_EXC_EN, E_EXC_CODE, CP_C_OPCODE, CP_E_ALLOW
  );

  // Core plus cop-slot view, i.e. whatever surrounds the dispatcher
  modport master (
    output FLUSH, STALL, C_VALID, C_OPCODE, E_ALLOW,
           CP_C_ACCEPT, CP_E_VALID, CP_E_REG_W_EN, CP_E_EXC_EN,
           CP_E_REG_W_RD, CP_E_REG_W_DATA, CP_E_EXC_CODE,
    input  C_ACCEPT, E_VALID, E_REG_W_EN, E_REG_W_RD, E_REG_W_DATA,
           E_EXC_EN, E_EXC_CODE, CP_C_OPCODE, CP_E_ALLOW
  );

endinterface

// File: rtl/cop_dispatcher.sv
// Shares the core's coprocessor Check/Ready/Exec interface among NUM_COP
// slots. The Check opcode is broadcast, the lowest-index acceptor becomes the
// owner, ownership follows the instruction through Ready and Exec, only the
// owner gets exec permission, and a silent owner ends in a timeout exception.
module cop_dispatcher #(
  parameter int         NUM_COP = 2,
  parameter int         TIMEOUT = 64,
  parameter logic [3:0] EXC_TMO = 4'd2
) (
  input  logic             CLK,
  input  logic             RST,
  cop_dispatcher_if.slave  bus
);

  localparam int SEL_W = (NUM_COP > 1) ? $clog2(NUM_COP) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TMO  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_rVld;
  logic               r_eVld;
  logic [SEL_W-1:0]   r_rSel;
  logic [SEL_W-1:0]   r_eSel;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [SEL_W-1:0]   w_grant;
  logic               w_accept;
  logic               w_done;
  logic [NUM_COP-1:0] w_cpAllow;
  logic               w_eValid;
  logic               w_eRegWEn;
  logic [4:0]         w_eRegWRd;
  logic [31:0]        w_eRegWData;
  logic               w_eExcEn;
  logic [3:0]         w_eExcCode;

  // Lowest-index acceptor wins: scan downwards so the last hit is the lowest
  always_comb begin
    w_grant = '0;
    for (int i = NUM_COP - 1; i >= 0; i--) begin
      if (bus.CP_C_ACCEPT[i]) w_grant = SEL_W'(i);
    end
  end

  assign w_accept        = bus.C_VALID & (|bus.CP_C_ACCEPT);
  assign bus.C_ACCEPT    = w_accept;
  assign bus.CP_C_OPCODE = bus.C_OPCODE;

  // Check->Ready->Exec ownership pipeline; a finished instruction is dropped from Exec while the core stalls
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rVld <= 1'b0;
      r_eVld <= 1'b0;
      r_rSel <= '0;
      r_eSel <= '0;
    end else if (bus.FLUSH) begin
      r_rVld <= 1'b0;
      r_eVld <= 1'b0;
    end else if (!bus.STALL) begin
      r_rVld <= w_accept;
      r_rSel <= w_grant;
      r_eVld <= r_rVld;
      r_eSel <= r_rSel;
    end else if (w_done) begin
      r_eVld <= 1'b0;
    end
  end

  // Exec FSM state and timeout counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
    end
  end

  // Exec FSM: grant exec to the owner, forward its result, or time it out; flush overrides everything
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    w_done      = 1'b0;
    w_cpAllow   = '0;
    w_eValid    = 1'b0;
    w_eRegWEn   = 1'b0;
    w_eRegWRd   = '0;
    w_eRegWData = '0;
    w_eExcEn    = 1'b0;
    w_eExcCode  = '0;
    case (r_state)
      IDLE: begin
        if (r_eVld && bus.E_ALLOW) begin
          w_nextState = RUN;
          w_cntNext   = '0;
        end
      end
      RUN: begin
        w_cpAllow = NUM_COP'(1) << r_eSel;
        if (bus.CP_E_VALID[r_eSel]) begin
          w_eValid    = 1'b1;
          w_eRegWEn   = bus.CP_E_REG_W_EN[r_eSel];
          w_eRegWRd   = bus.CP_E_REG_W_RD[int'(r_eSel) * 5 +: 5];
          w_eRegWData = bus.CP_E_REG_W_DATA[int'(r_eSel) * 32 +: 32];
          w_eExcEn    = bus.CP_E_EXC_EN[r_eSel];
          w_eExcCode  = bus.CP_E_EXC_CODE[int'(r_eSel) * 4 +: 4];
          w_done      = 1'b1;
          w_nextState = IDLE;
          w_cntNext   = '0;
        end else if (!bus.E_ALLOW) begin
          w_nextState = IDLE;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_nextState = TMO;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      TMO: begin
        w_eValid    = 1'b1;
        w_eExcEn    = 1'b1;
        w_eExcCode  = EXC_TMO;
        w_done      = 1'b1;
        w_nextState = IDLE;
        w_cntNext   = '0;
      end
      default: begin
        w_nextState = IDLE;
        w_cntNext   = '0;
      end
    endcase
    if (bus.FLUSH) begin
      w_nextState = IDLE;
      w_cntNext   = '0;
      w_done      = 1'b0;
      w_cpAllow   = '0;
      w_eValid    = 1'b0;
      w_eRegWEn   = 1'b0;
      w_eRegWRd   = '0;
      w_eRegWData = '0;
      w_eExcEn    = 1'b0;
      w_eExcCode  = '0;
    end
  end

  assign bus.CP_E_ALLOW   = w_cpAllow;
  assign bus.E_VALID      = w_eValid;
  assign bus.E_REG_W_EN   = w_eRegWEn;
  assign bus.E_REG_W_RD   = w_eRegWRd;
  assign bus.E_REG_W_DATA = w_eRegWData;
  assign bus.E_EXC_EN     = w_eExcEn;
  assign bus.E_EXC_CODE   = w_eExcCode;

endmodule

// File: tb/tb_cop_dispatcher.sv
// Directed bench for cop_dispatcher with two cop slots and a 64-cycle timeout.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_cop_dispatcher;

  logic CLK;
  logic RST;
  int   numChecks;
  int   numPassed;

  cop_dispatcher_if #(.NUM_COP(2)) bus ();

  cop_dispatcher #(
    .NUM_COP (2),
    .TIMEOUT (64),
    .EXC_TMO (4'd2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected end before time 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numChecks++;
    if (obs === exp) numPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nextCycle();
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic cv, input logic [1:0] acc, input logic ea,
                               input logic st, input logic fl);
    bus.C_VALID     = cv;
    bus.CP_C_ACCEPT = acc;
    bus.E_ALLOW     = ea;
    bus.STALL       = st;
    bus.FLUSH       = fl;
    #1;
  endtask

  task automatic setCop(input logic [1:0] vld, input logic [1:0] wen, input logic [9:0] rd,
                        input logic [63:0] data, input logic [1:0] exc, input logic [7:0] code);
    bus.CP_E_VALID      = vld;
    bus.CP_E_REG_W_EN   = wen;
    bus.CP_E_REG_W_RD   = rd;
    bus.CP_E_REG_W_DATA = data;
    bus.CP_E_EXC_EN     = exc;
    bus.CP_E_EXC_CODE   = code;
  endtask

  task automatic idleCops();
    setCop(2'b00, 2'b00, 10'd0, 64'd0, 2'b00, 8'd0);
  endtask

  // Check, Ready, then Exec with E_ALLOW and STALL raised; returns at the first RUN cycle
  task automatic issue(input logic [1:0] mask, input logic expAcc);
    bus.C_OPCODE = 17'h1A5A5;
    applyStimulus(1'b1, mask, 1'b0, 1'b0, 1'b0);
    checkOutput("c_accept", {63'd0, bus.C_ACCEPT}, {63'd0, expAcc});
    checkOutput("cp_c_opcode", {47'd0, bus.CP_C_OPCODE}, 64'h1A5A5);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("idle_no_allow", {62'd0, bus.CP_E_ALLOW}, 64'd0);
    nextCycle();
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_allow"}, {62'd0, bus.CP_E_ALLOW}, 64'd0);
    checkOutput({tag, "_e_valid"}, {63'd0, bus.E_VALID}, 64'd0);
  endtask

  initial begin
    numChecks = 0;
    numPassed = 0;
    RST = 1'b0;
    bus.C_OPCODE = '0;
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset state
    checkOutput("rst_c_accept", {63'd0, bus.C_ACCEPT}, 64'd0);
    checkQuiet("rst");
    checkOutput("rst_exc_en", {63'd0, bus.E_EXC_EN}, 64'd0);
    nextCycle();
    RST = 1'b1;

    // Both accept: cop0 owns, answers on the third RUN cycle; cop1 noise ignored
    issue(2'b11, 1'b1);
    setCop(2'b10, 2'b10, {5'd9, 5'd0}, {32'hAAAA5555, 32'd0}, 2'b00, 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_allow1", {62'd0, bus.CP_E_ALLOW}, 64'd1);
    checkOutput("t1_nonowner_ignored", {63'd0, bus.E_VALID}, 64'd0);
    nextCycle();
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_allow2", {62'd0, bus.CP_E_ALLOW}, 64'd1);
    nextCycle();
    setCop(2'b11, 2'b11, {5'd9, 5'd3}, {32'hAAAA5555, 32'h12345678}, 2'b00, 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_e_valid", {63'd0, bus.E_VALID}, 64'd1);
    checkOutput("t1_w_en", {63'd0, bus.E_REG_W_EN}, 64'd1);
    checkOutput("t1_w_rd", {59'd0, bus.E_REG_W_RD}, 64'd3);
    checkOutput("t1_w_data", {32'd0, bus.E_REG_W_DATA}, 64'h12345678);
    checkOutput("t1_exc_en", {63'd0, bus.E_EXC_EN}, 64'd0);
    nextCycle();
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkQuiet("t1_after");

    // Only cop1 accepts: cop0 valid ignored, cop1 writes DEADBEEF to x5
    issue(2'b10, 1'b1);
    setCop(2'b01, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h11111111}, 2'b00, 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_allow1", {62'd0, bus.CP_E_ALLOW}, 64'd2);
    checkOutput("t2_cop0_ignored", {63'd0, bus.E_VALID}, 64'd0);
    nextCycle();
    setCop(2'b10, 2'b10, {5'd5, 5'd7}, {32'hDEADBEEF, 32'h0BADF00D}, 2'b00, 8'h0F);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_allow2", {62'd0, bus.CP_E_ALLOW}, 64'd2);
    checkOutput("t2_e_valid", {63'd0, bus.E_VALID}, 64'd1);
    checkOutput("t2_w_en", {63'd0, bus.E_REG_W_EN}, 64'd1);
    checkOutput("t2_w_rd", {59'd0, bus.E_REG_W_RD}, 64'd5);
    checkOutput("t2_w_data", {32'd0, bus.E_REG_W_DATA}, 64'hDEADBEEF);
    nextCycle();
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkQuiet("t2_after");

    // Silent owner: 64 RUN cycles, then a one-cycle timeout exception
    issue(2'b01, 1'b1);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      checkOutput("t3_run_allow", {62'd0, bus.CP_E_ALLOW}, 64'd1);
      checkOutput("t3_run_e_valid", {63'd0, bus.E_VALID}, 64'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_tmo_e_valid", {63'd0, bus.E_VALID}, 64'd1);
    checkOutput("t3_tmo_exc_en", {63'd0, bus.E_EXC_EN}, 64'd1);
    checkOutput("t3_tmo_exc_code", {60'd0, bus.E_EXC_CODE}, 64'd2);
    checkOutput("t3_tmo_w_en", {63'd0, bus.E_REG_W_EN}, 64'd0);
    checkOutput("t3_tmo_allow", {62'd0, bus.CP_E_ALLOW}, 64'd0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkQuiet("t3_after");

    // Flush on the second RUN cycle kills allow and result at once
    issue(2'b01, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_allow1", {62'd0, bus.CP_E_ALLOW}, 64'd1);
    nextCycle();
    setCop(2'b01, 2'b01, {5'd0, 5'd4}, {32'd0, 32'h55AA55AA}, 2'b00, 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    checkQuiet("t4_flush");
    nextCycle();
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkQuiet("t4_post1");
    nextCycle();
    checkQuiet("t4_post2");
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // No acceptor: nothing ever reaches exec
    issue(2'b00, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkQuiet("t5_none1");
    nextCycle();
    checkQuiet("t5_none2");
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    nextCycle();

    // STALL freezes the owner selection captured before it (cop1)
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_acc_cop1", {63'd0, bus.C_ACCEPT}, 64'd1);
    nextCycle();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_idle_allow", {62'd0, bus.CP_E_ALLOW}, 64'd0);
    nextCycle();
    setCop(2'b10, 2'b10, {5'd2, 5'd0}, {32'hCAFEF00D, 32'd0}, 2'b00, 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_frozen_allow", {62'd0, bus.CP_E_ALLOW}, 64'd2);
    checkOutput("t5_e_valid", {63'd0, bus.E_VALID}, 64'd1);
    checkOutput("t5_w_data", {32'd0, bus.E_REG_W_DATA}, 64'hCAFEF00D);
    nextCycle();
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in RUN clears outputs immediately; next instruction works
    issue(2'b01, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_allow_before", {62'd0, bus.CP_E_ALLOW}, 64'd1);
    #2;
    setCop(2'b01, 2'b01, {5'd0, 5'd1}, {32'd0, 32'h77777777}, 2'b00, 8'd0);
    RST = 1'b0;
    #1;
    checkQuiet("t6_in_reset");
    checkOutput("t6_rst_w_en", {63'd0, bus.E_REG_W_EN}, 64'd0);
    nextCycle();
    RST = 1'b1;
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(2'b01, 1'b1);
    setCop(2'b01, 2'b01, {5'd0, 5'd10}, {32'd0, 32'h600DCAFE}, 2'b00, 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_e_valid", {63'd0, bus.E_VALID}, 64'd1);
    checkOutput("t6_w_rd", {59'd0, bus.E_REG_W_RD}, 64'd10);
    checkOutput("t6_w_data", {32'd0, bus.E_REG_W_DATA}, 64'h600DCAFE);
    nextCycle();
    idleCops();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkQuiet("t6_after");

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
